mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 tri-state mux output between four requesters.
- Drives the mux select pair and the mux enable directly; the mux enable gates the 2-to-4 decoder, so at most one tri-state buffer ever drives the output.
- Adds a bounded hold time so that no requester can starve the others.
- Sits between the requesting sources and the mux select/enable pins.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the bus while others wait. 0 disables preemption. Legal range 0..255.
- CW, 8: width of the internal hold counter. Must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per source; bit k requests mux input ik.
- s0  output  1  mux select LSB (owner index bit 0).
- s1  output  1  mux select MSB (owner index bit 1).
- e  output  1  mux/decoder enable; 1 while a grant is active.
- gnt  output  4  one-hot grant. gnt[k]=1 iff e=1 and {s1,s0}=k.
- preempt  output  1  one-cycle pulse in the cycle after the owner was removed by timeout.

Behaviour:
- Registers: state (IDLE/BUSY), owner[1:0], ptr[1:0] (search start), hold_cnt[CW-1:0]. All outputs are registered.
- Reset, asynchronous on rst_n=0, immediate regardless of state: state=IDLE, owner=0, ptr=0, hold_cnt=0, e=0, s1=0, s0=0, gnt=0000, preempt=0. Any active grant is dropped at once and the mux output floats to Z.
- Arbitration function pick(mask): first index j, scanning ptr, ptr+1, ... mod 4, with mask[j]=1.
- Latency: a req sampled at edge N produces a grant visible after edge N (one cycle). There is no combinational path from req to any output.
- IDLE state:
  - If req!=0: go to BUSY, owner=pick(req), hold_cnt=0, ptr=owner+1 mod 4.
  - Otherwise remain IDLE with e=0.
- BUSY state, evaluated each edge in this priority order:
  1. Release (req[owner]=0):
     - If other requests are pending, regrant immediately: owner=pick(req), hold_cnt=0, ptr=owner+1. There is no idle gap.
     - If no other requests are pending, go to IDLE; e=0 and gnt=0000 from the next cycle.
  2. Timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[owner]=1):
     - If others are requesting: owner=pick(req & ~onehot(owner)), hold_cnt=0, ptr=owner+1, preempt=1 for one cycle.
     - If only the owner is requesting: same owner, hold_cnt=0, preempt=0.
  3. Otherwise: hold_cnt=hold_cnt+1, with no change in grant.
- preempt is 0 in every cycle other than case 2 with a switch.
- The owner is granted for exactly MAX_HOLD cycles before a timeout switch.
- Simultaneous release by the owner and new requests elsewhere: release path (case 1); preempt=0.
- Requests that rise and fall while not granted are ignored; there is no latching of requests.
- The counter never wraps: it is cleared on every grant change.
- Invariants, checked in every cycle:
  - gnt is 0000 or exactly one-hot.
  - e == |gnt.
  - e=1 implies {s1,s0} equals the index of the set gnt bit.

Test Plan:
- Reset mid-grant: hold req=0100 until BUSY, then pull rst_n low between clock edges -> e=0, gnt=0000, {s1,s0}=00 immediately. After release with req=0100 -> grant on the first edge, owner 2.
- Single request: req=0010 from IDLE -> after 1 edge: e=1, {s1,s0}=01, gnt=0010. Drop req -> after 1 edge: e=0, gnt=0000.
- Round-robin order: hold req=1111, each owner drops its req for one cycle after 2 cycles of ownership -> grant sequence 0,1,2,3,0 with no idle cycles between owners.
- Preemption (MAX_HOLD=8):
  - req[0] held continuously and req[3] asserted at cycle 2 -> owner 0 for exactly 8 cycles, then owner 3, with preempt=1 for one cycle.
  - Lone req[0] held for 20 cycles -> owner 0 throughout, preempt never 1.
- Simultaneous release: owner 1 drops req in the same edge that req[2] rises -> next cycle gnt=0100, preempt=0.
- MAX_HOLD=0: req=0011 held for 100 cycles -> owner 0 for all 100 cycles, preempt never 1.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/select/grant bundle between requesters, arbiter and 4:1 tri-state mux
//
// Signals:
//   req[3:0]  request per source, bit k asks for mux input k
//   s0, s1    mux select LSB/MSB (owner index)
//   e         mux/decoder enable, 1 while a grant is active
//   gnt[3:0]  one-hot grant, all zero when e=0
//   preempt   one-cycle pulse after the owner was removed by timeout
// Modports:
//   master    arbiter side (consumes req, drives select/enable/grant)
//   slave     requester/mux side

interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic       s0;
    logic       s1;
    logic       e;
    logic [3:0] gnt;
    logic       preempt;

    modport master (input req, output s0, s1, e, gnt, preempt);
    modport slave  (output req, input s0, s1, e, gnt, preempt);
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter with bounded hold driving a 4:1 tri-state mux
//
// Parameters:
//   MAX_HOLD  cycles an owner may keep the bus while others wait (0 = never preempt)
//   CW        hold counter width, 2^CW > MAX_HOLD
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       mux_rr_arbiter_if.master: req in; s0, s1, e, gnt, preempt out (all registered)

module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_rr_arbiter_if.master      bus
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Counter value seen in the last cycle an owner may hold while others wait.
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);

    state_t        state, state_nxt;
    logic [1:0]    owner, owner_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [CW-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]    gnt_q, gnt_nxt;
    logic          preempt_q, preempt_nxt;

    logic [3:0]    others;
    logic [1:0]    pick_all;
    logic [1:0]    pick_oth;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // First set bit of mask scanning start, start+1, ... modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 2'd0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt_q     <= 4'b0000;
            preempt_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt_q     <= gnt_nxt;
            preempt_q <= preempt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        preempt_nxt  = 1'b0;

        others   = bus.req & ~onehot(owner);
        pick_all = pick(bus.req, ptr);
        pick_oth = pick(others, ptr);

        case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_nxt    = BUSY;
                    owner_nxt    = pick_all;
                    ptr_nxt      = pick_all + 2'd1;
                    hold_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (!bus.req[owner]) begin
                    // Owner let go: hand over without an idle gap if anyone waits.
                    if (bus.req != 4'b0000) begin
                        owner_nxt    = pick_all;
                        ptr_nxt      = pick_all + 2'd1;
                        hold_cnt_nxt = '0;
                    end else begin
                        state_nxt    = IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    // Hold budget used up; a lone owner simply starts a fresh budget.
                    hold_cnt_nxt = '0;
                    if (others != 4'b0000) begin
                        owner_nxt   = pick_oth;
                        ptr_nxt     = pick_oth + 2'd1;
                        preempt_nxt = 1'b1;
                    end
                end else if (MAX_HOLD != 0) begin
                    // With preemption disabled the counter is frozen so it can never wrap.
                    hold_cnt_nxt = hold_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        gnt_nxt = (state_nxt == BUSY) ? onehot(owner_nxt) : 4'b0000;
    end

    assign bus.e       = (state == BUSY);
    assign bus.s0      = owner[0];
    assign bus.s1      = owner[1];
    assign bus.gnt     = gnt_q;
    assign bus.preempt = preempt_q;

endmodule
